// File: rtl/eth_rst_pkg.sv
// Shared definitions for the Ethernet reset-release sequencer: state encoding,
// timing defaults and the per-state output decode.
package eth_rst_pkg;

  localparam int unsigned CNT_W            = 24;
  localparam int unsigned STAGE_DELAY_DEF  = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF = 1000000;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_REL_PMA   = 3'd2,
    ST_REL_PCS   = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_REL_MAC   = 3'd5,
    ST_READY     = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  typedef struct packed {
    logic pma_reset;
    logic pcs_reset;
    logic mac_reset;
    logic link_ready;
    logic init_error;
  } outs_t;

  // Output levels held while resident in a given state.
  function automatic outs_t state_outputs(input state_e st);
    outs_t o;
    o = '{pma_reset: 1'b1, pcs_reset: 1'b1, mac_reset: 1'b1,
          link_ready: 1'b0, init_error: 1'b0};
    case (st)
      ST_REL_PMA:   o.pma_reset = 1'b0;
      ST_REL_PCS,
      ST_WAIT_LOCK: begin
        o.pma_reset = 1'b0;
        o.pcs_reset = 1'b0;
      end
      ST_REL_MAC: begin
        o.pma_reset = 1'b0;
        o.pcs_reset = 1'b0;
        o.mac_reset = 1'b0;
      end
      ST_READY: begin
        o.pma_reset  = 1'b0;
        o.pcs_reset  = 1'b0;
        o.mac_reset  = 1'b0;
        o.link_ready = 1'b1;
      end
      ST_FAULT:     o.init_error = 1'b1;
      default:      ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-low reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/reset_release_sequencer.sv
// Staged PMA -> PCS -> MAC reset release for a 64b/66b link, gated by init
// completion, PLL lock and PCS block lock, with a sticky fault state.
module reset_release_sequencer
  import eth_rst_pkg::*;
#(
  parameter int unsigned STAGE_DELAY  = STAGE_DELAY_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_reset_req,
  input  logic       i_await_init,
  input  logic       i_pll_locked,
  input  logic       i_block_lock,
  output logic       o_pma_reset,
  output logic       o_pcs_reset,
  output logic       o_mac_reset,
  output logic       o_link_ready,
  output logic       o_init_error,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

  logic req_s, await_s, pll_s, lock_s;

  sync_2ff u_sync_req   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_reset_req),  .o_q(req_s));
  sync_2ff u_sync_await (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_await_init), .o_q(await_s));
  sync_2ff u_sync_pll   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_pll_locked), .o_q(pll_s));
  sync_2ff u_sync_lock  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_block_lock), .o_q(lock_s));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  outs_t            out_q, out_d;

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;

    case (state_q)
      ST_HOLD:      if (!req_s) state_d = ST_WAIT_INIT;
      ST_WAIT_INIT: begin
        if (await_s) seen_d = 1'b1;
        if (seen_q && !await_s && pll_s) state_d = ST_REL_PMA;
      end
      ST_REL_PMA:   if (cnt_q == STAGE_LAST) state_d = ST_REL_PCS;
      ST_REL_PCS:   if (cnt_q == STAGE_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)                  state_d = ST_REL_MAC;
        else if (cnt_q == LOCK_LAST) state_d = ST_FAULT;
      end
      ST_REL_MAC:   if (cnt_q == STAGE_LAST) state_d = ST_READY;
      ST_READY:     if (!lock_s) state_d = ST_WAIT_LOCK;
      ST_FAULT:     ;
      default:      state_d = ST_HOLD;
    endcase

    // Overrides in ascending priority: PLL loss while releasing/up, then reset request.
    if (!pll_s && (state_q inside {ST_REL_PMA, ST_REL_PCS, ST_WAIT_LOCK,
                                   ST_REL_MAC, ST_READY}))
      state_d = ST_FAULT;
    if (req_s) begin
      state_d = ST_HOLD;
      seen_d  = 1'b0;
    end

    // Counter restarts on every state entry and saturates rather than wrapping.
    if (req_s || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q == '1)              cnt_d = cnt_q;
    else                               cnt_d = cnt_q + CNT_W'(1);

    out_d = state_outputs(state_d);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      out_q   <= state_outputs(ST_HOLD);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      out_q   <= out_d;
    end
  end

  assign o_pma_reset  = out_q.pma_reset;
  assign o_pcs_reset  = out_q.pcs_reset;
  assign o_mac_reset  = out_q.mac_reset;
  assign o_link_ready = out_q.link_ready;
  assign o_init_error = out_q.init_error;
  assign o_state      = state_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with STAGE_DELAY=4, LOCK_TIMEOUT=100.
module tb_reset_release_sequencer;

  // Expected {pma, pcs, mac, link_ready, init_error, state[2:0]} per state.
  localparam logic [7:0] E_HOLD      = 8'b111_0_0_000;
  localparam logic [7:0] E_WAIT_INIT = 8'b111_0_0_001;
  localparam logic [7:0] E_REL_PMA   = 8'b011_0_0_010;
  localparam logic [7:0] E_REL_PCS   = 8'b001_0_0_011;
  localparam logic [7:0] E_WAIT_LOCK = 8'b001_0_0_100;
  localparam logic [7:0] E_REL_MAC   = 8'b000_0_0_101;
  localparam logic [7:0] E_READY     = 8'b000_1_0_110;
  localparam logic [7:0] E_FAULT     = 8'b111_0_1_111;

  logic       clk = 1'b0;
  logic       rst_n, reset_req, await_init, pll_locked, block_lock;
  logic       pma_reset, pcs_reset, mac_reset, link_ready, init_error;
  logic [2:0] state;
  logic [7:0] obs_v;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  always #5 clk = ~clk;

  reset_release_sequencer #(
    .STAGE_DELAY (4),
    .LOCK_TIMEOUT(100)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_reset_req (reset_req),
    .i_await_init(await_init),
    .i_pll_locked(pll_locked),
    .i_block_lock(block_lock),
    .o_pma_reset (pma_reset),
    .o_pcs_reset (pcs_reset),
    .o_mac_reset (mac_reset),
    .o_link_ready(link_ready),
    .o_init_error(init_error),
    .o_state     (state)
  );

  assign obs_v = {pma_reset, pcs_reset, mac_reset, link_ready, init_error, state};

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    vectors++;
    assert (obs_v === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs_v, exp);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no completion, expected $finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; reset_req = 1'b0; await_init = 1'b0;
    pll_locked = 1'b0; block_lock = 1'b0;
    step(2);
    chk("reset_state", E_HOLD);

    rst_n = 1'b1;
    step(1);
    chk("hold_to_wait_init", E_WAIT_INIT);

    // Reset-request pulse: 2 sync edges then the register edge.
    reset_req = 1'b1;
    step(2);
    chk("req_latency_2", E_WAIT_INIT);
    step(1);
    chk("req_to_hold", E_HOLD);
    reset_req = 1'b0;
    step(3);
    chk("req_release", E_WAIT_INIT);

    // Full bring-up.
    await_init = 1'b1;
    step(3);
    chk("await_high_stays", E_WAIT_INIT);
    await_init = 1'b0; pll_locked = 1'b1;
    step(3);
    chk("rel_pma_entry", E_REL_PMA);
    step(3);
    chk("rel_pma_hold_4", E_REL_PMA);
    step(1);
    chk("rel_pcs_entry", E_REL_PCS);
    step(3);
    chk("rel_pcs_hold_4", E_REL_PCS);
    step(1);
    chk("wait_lock_entry", E_WAIT_LOCK);
    step(16);
    block_lock = 1'b1;
    step(2);
    chk("lock_latency_2", E_WAIT_LOCK);
    step(1);
    chk("rel_mac_entry", E_REL_MAC);
    step(3);
    chk("rel_mac_hold_4", E_REL_MAC);
    step(1);
    chk("ready", E_READY);

    // Block lock lost while READY, then restored.
    block_lock = 1'b0;
    step(2);
    chk("ready_drop_lat_2", E_READY);
    step(1);
    chk("ready_to_wait_lock", E_WAIT_LOCK);
    block_lock = 1'b1;
    step(3);
    chk("relock_rel_mac", E_REL_MAC);
    step(3);
    chk("relock_mac_hold", E_REL_MAC);
    step(1);
    chk("relock_ready", E_READY);

    // Hard reset in REL_MAC aborts on the next edge.
    block_lock = 1'b0;
    step(3);
    block_lock = 1'b1;
    step(3);
    chk("pre_abort_rel_mac", E_REL_MAC);
    rst_n = 1'b0;
    step(1);
    chk("rst_abort_rel_mac", E_HOLD);

    // Lock timeout.
    block_lock = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk("t2_wait_init", E_WAIT_INIT);
    await_init = 1'b1;
    step(3);
    await_init = 1'b0;
    step(3);
    chk("t2_rel_pma", E_REL_PMA);
    step(8);
    chk("t2_wait_lock", E_WAIT_LOCK);
    step(99);
    chk("timeout_minus_1", E_WAIT_LOCK);
    step(1);
    chk("timeout_fault", E_FAULT);
    step(20);
    chk("fault_sticky", E_FAULT);
    reset_req = 1'b1;
    step(3);
    chk("fault_req_hold", E_HOLD);
    reset_req = 1'b0;
    step(3);
    chk("fault_exit_wait_init", E_WAIT_INIT);

    // PLL loss during REL_PCS.
    await_init = 1'b1;
    step(3);
    await_init = 1'b0;
    step(3);
    chk("t3_rel_pma", E_REL_PMA);
    step(4);
    chk("t3_rel_pcs", E_REL_PCS);
    pll_locked = 1'b0;
    step(2);
    chk("pll_drop_lat_2", E_REL_PCS);
    step(1);
    chk("pll_drop_fault", E_FAULT);
    reset_req = 1'b1;
    step(3);
    chk("pll_fault_req_hold", E_HOLD);
    reset_req = 1'b0;
    pll_locked = 1'b1;
    step(3);
    chk("t4_wait_init", E_WAIT_INIT);

    // Seen-await was cleared by the request: must not advance without a new await pulse.
    step(5000);
    chk("no_await_5000", E_WAIT_INIT);
    step(5000);
    chk("no_await_10000", E_WAIT_INIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
RESET_RELEASE_SEQUENCER -- requirements
Module: reset_release_sequencer

Interface
REQ-001 Parameter STAGE_DELAY, default 16: i_clk cycles between successive reset-release stages; legal range 1..2^24-1.
REQ-002 Parameter LOCK_TIMEOUT, default 1000000: maximum i_clk cycles to wait for PCS block lock; legal range 1..2^24-1.
REQ-003 i_clk  input  1  single clock for the block; rising-edge only.
REQ-004 i_rst_n  input  1  reset, synchronous to i_clk, active-low.
REQ-005 i_reset_req  input  1  reset request from the slow-clock reset/init generator; asynchronous to i_clk.
REQ-006 i_await_init  input  1  init-in-progress flag from the same generator; asynchronous to i_clk.
REQ-007 i_pll_locked  input  1  transceiver PLL lock; asynchronous to i_clk.
REQ-008 i_block_lock  input  1  PCS 64b/66b block lock; asynchronous to i_clk.
REQ-009 o_pma_reset  output  1  PMA reset; active-high.
REQ-010 o_pcs_reset  output  1  PCS reset; active-high.
REQ-011 o_mac_reset  output  1  MAC reset; active-high.
REQ-012 o_link_ready  output  1  link fully up.
REQ-013 o_init_error  output  1  sticky fault flag.
REQ-014 o_state  output  3  current FSM state, for debug.

Function
REQ-015 All four asynchronous inputs SHALL pass through 2-flop synchronizers; the FSM SHALL use only synchronized values.
REQ-016 All outputs SHALL be registered; an output response SHALL appear 3 i_clk edges after an input change: 2 synchronizer edges plus 1 register edge.
REQ-017 FSM states: HOLD=0, WAIT_INIT=1, REL_PMA=2, REL_PCS=3, WAIT_LOCK=4, REL_MAC=5, READY=6, FAULT=7.
REQ-018 Synchronized i_reset_req high SHALL force HOLD from any state. It takes priority over all other transitions and clears the stage counter and the seen-await flag.
REQ-019 HOLD: all three resets asserted, o_link_ready=0, o_init_error=0.
REQ-020 HOLD -> WAIT_INIT when synchronized i_reset_req is low.
REQ-021 WAIT_INIT: set the sticky seen-await flag whenever i_await_init is high.
- Transition to REL_PMA when the flag is set, i_await_init is low and i_pll_locked is high.
- Remain in WAIT_INIT indefinitely otherwise.
REQ-022 REL_PMA: o_pma_reset=0; count STAGE_DELAY cycles, then -> REL_PCS.
REQ-023 REL_PCS: o_pcs_reset=0; count STAGE_DELAY cycles, then -> WAIT_LOCK.
REQ-024 WAIT_LOCK: count cycles.
- -> REL_MAC on i_block_lock high.
- -> FAULT when the count reaches LOCK_TIMEOUT.
- If both occur in the same cycle, lock wins.
REQ-025 REL_MAC: o_mac_reset=0; count STAGE_DELAY cycles, then -> READY.
REQ-026 READY: o_link_ready=1.
- i_block_lock low -> WAIT_LOCK: o_mac_reset=1, o_link_ready=0, counter cleared.
REQ-027 i_pll_locked low in any state from REL_PMA to READY SHALL transition to FAULT. This takes priority over every transition except REQ-018.
REQ-028 FAULT: all resets asserted, o_link_ready=0, o_init_error=1; exit only via REQ-018.
REQ-029 The stage counter SHALL be 24 bits, cleared on every state entry, and SHALL never wrap.

Reset
REQ-030 When i_rst_n is low at a rising edge:
- state=HOLD;
- o_pma_reset, o_pcs_reset, o_mac_reset = 1;
- o_link_ready = 0, o_init_error = 0, o_state = 0;
- counter and seen-await flag = 0;
- synchronizer flops = 0.
REQ-031 Reset mid-sequence SHALL abort immediately with no partial stage release.

Structure
REQ-032 The state encoding and the STAGE_DELAY/LOCK_TIMEOUT defaults SHALL live in the shared package eth_rst_pkg.
REQ-033 The synchronizer SHALL be sub-module sync_2ff (1-bit), instantiated four times.

Verification
REQ-034 STAGE_DELAY=4, LOCK_TIMEOUT=100. Stimulus: reset_req pulse; await 1 then 0; pll=1; block_lock at cycle 20 of WAIT_LOCK. Required response:
- PMA, PCS and MAC resets release 4 cycles apart;
- o_link_ready=1;
- o_state passes 0..6 in order.
REQ-035 Block lock never asserted -> FAULT exactly 100 cycles after WAIT_LOCK entry; o_init_error=1; all resets=1.
REQ-036 pll_locked dropped in REL_PCS -> FAULT within 3 cycles; a later reset_req pulse -> HOLD with o_init_error=0.
REQ-037 block_lock dropped in READY -> o_link_ready=0 and o_mac_reset=1 after 3 cycles; lock restored -> READY after a further 4 cycles plus sync latency.
REQ-038 Both checks:
- await_init never high -> the FSM stays in WAIT_INIT for 10000 cycles;
- i_rst_n low during REL_MAC -> all resets=1 on the next edge.
